elevator_scheduler: RTL

- Request scheduler and sequencer for the 3-floor elevator car (floors 0 = ground, 1 = first, 2 = second).
- Latches hall/car call buttons into a pending-request register and picks the next target floor with SCAN ordering (keep direction while calls remain ahead).
- Times floor-to-floor travel and door dwell from a slow tick enable.
- Drives current/next floor codes to the 7-seg display path and the emergency indicator.

---
 rtl/elevator_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// Three-floor elevator request scheduler: latches calls, picks targets with
// SCAN ordering, times travel/door dwell from a slow tick, and drives the
// floor display codes plus the emergency indicator.
module elevator_scheduler #(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [2:0]       btn,
  input  logic             emerg_in,
  output logic [1:0]       cur_floor,
  output logic [1:0]       next_floor,
  output logic [3:0]       Disp_1,
  output logic [3:0]       Disp_2,
  output logic             moving,
  output logic             door_open,
  output logic             dir_up,
  output logic [2:0]       pending,
  output logic             emerg_out
);

  typedef enum logic [1:0] {S_IDLE, S_MOVING, S_DOOR, S_EMERG} state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cur_floor_next, next_floor_next;
  logic [2:0]       pending_next;
  logic             dir_up_next;

  logic [2:0]       cur_oh, step_oh;
  logic [1:0]       step_floor;
  logic             up_found, dn_found;
  logic [1:0]       up_floor, dn_floor;

  // Nearest pending floor above and below the car, plus the floor one step toward the target
  always_comb begin
    up_found = 1'b0;
    up_floor = cur_floor;
    dn_found = 1'b0;
    dn_floor = cur_floor;
    // scanning downward leaves the closest floor above as the last hit
    for (int f = 2; f >= 0; f--) begin
      if (pending[f] && (2'(f) > cur_floor)) begin
        up_found = 1'b1;
        up_floor = 2'(f);
      end
    end
    // scanning upward leaves the closest floor below as the last hit
    for (int f = 0; f <= 2; f++) begin
      if (pending[f] && (2'(f) < cur_floor)) begin
        dn_found = 1'b1;
        dn_floor = 2'(f);
      end
    end
    step_floor = (next_floor > cur_floor) ? cur_floor + 2'd1 : cur_floor - 2'd1;
    cur_oh     = 3'b001 << cur_floor;
    step_oh    = 3'b001 << step_floor;
  end

  // State register: all sequential state, displays load the same values as the floor codes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      cur_floor  <= 2'd0;
      next_floor <= 2'd0;
      pending    <= 3'b000;
      dir_up     <= 1'b1;
      Disp_1     <= 4'd0;
      Disp_2     <= 4'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      cur_floor  <= cur_floor_next;
      next_floor <= next_floor_next;
      pending    <= pending_next;
      dir_up     <= dir_up_next;
      Disp_1     <= {2'b00, cur_floor_next};
      Disp_2     <= {2'b00, next_floor_next};
    end
  end

  // Next-state logic: emergency first, then per-state scheduling; a clear beats a same-cycle press
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cur_floor_next  = cur_floor;
    next_floor_next = next_floor;
    dir_up_next     = dir_up;
    pending_next    = pending | btn;
    if (state_reg == S_EMERG) begin
      pending_next = 3'b000;
    end else if (emerg_in) begin
      state_next      = S_EMERG;
      pending_next    = 3'b000;
      next_floor_next = cur_floor;
      cnt_next        = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if ((pending & cur_oh) != 3'b000) begin
            pending_next = pending_next & ~cur_oh;
            cnt_next     = '0;
            state_next   = S_DOOR;
          end else if (pending != 3'b000) begin
            if (dir_up) begin
              if (up_found) begin
                next_floor_next = up_floor;
              end else begin
                next_floor_next = dn_floor;
                dir_up_next     = 1'b0;
              end
            end else begin
              if (dn_found) begin
                next_floor_next = dn_floor;
              end else begin
                next_floor_next = up_floor;
                dir_up_next     = 1'b1;
              end
            end
            cnt_next   = '0;
            state_next = S_MOVING;
          end else begin
            next_floor_next = cur_floor;
          end
        end
        S_MOVING: begin
          if (tick) begin
            if (cnt_reg == TRAVEL_LAST) begin
              cur_floor_next = step_floor;
              cnt_next       = '0;
              // stop at the target, or at a call lying on the way
              if ((step_floor == next_floor) || ((pending & step_oh) != 3'b000)) begin
                pending_next = pending_next & ~step_oh;
                state_next   = S_DOOR;
              end
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        S_DOOR: begin
          // a press at the open floor only extends the dwell
          pending_next = pending | (btn & ~cur_oh);
          if ((btn & cur_oh) != 3'b000) begin
            cnt_next = '0;
          end else if (tick) begin
            if (cnt_reg == DOOR_LAST) begin
              cnt_next = '0;
              if (next_floor != cur_floor) begin
                state_next = S_MOVING;
              end else begin
                next_floor_next = cur_floor;
                state_next      = S_IDLE;
              end
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output flags decoded from the current state
  always_comb begin
    moving    = (state_reg == S_MOVING);
    door_open = (state_reg == S_DOOR);
    emerg_out = (state_reg == S_EMERG);
  end

endmodule
